// File: rtl/alu_uart_ctrl_pkg.sv
// Shared ALU opcode encodings, sequencer state encodings and flag bit positions.
// Imported by the ALU front-end sequencer. The ALU core uses the same opcode values.
package alu_uart_ctrl_pkg;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_NOR = 6'b100111;

  localparam int FLG_CARRY   = 0;
  localparam int FLG_INVALID = 1;

  typedef enum logic [2:0] {
    ST_WAIT_A,
    ST_WAIT_B,
    ST_WAIT_OP,
    ST_EXEC,
    ST_SEND_RES,
    ST_WAIT_RES,
    ST_SEND_FLG,
    ST_WAIT_FLG
  } state_t;

  function automatic logic op_known(input logic [5:0] op);
    logic known;
    known = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_SRA, OP_SRL, OP_NOR: known = 1'b1;
      default:                        known = 1'b0;
    endcase
    return known;
  endfunction

endpackage

// File: rtl/inter_byte_timer.sv
// Idle-gap timer between command bytes; expire is combinational and only fires while enabled.
// Clear always overrides expiry in the same cycle; the counter saturates instead of wrapping.
module inter_byte_timer #(
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt <= '0;
    end else if (i_clear) begin
      cnt <= '0;
    end else if (i_enable && (cnt != LAST)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign o_expire = i_enable && !i_clear && (cnt == LAST);

endmodule

// File: rtl/alu_uart_ctrl.sv
// Byte-stream ALU sequencer: rx A, B, opcode -> ALU -> tx result then flags; result tx_start 2 cycles after opcode byte.
// Flow control is the UART strobes only: tx waits on i_tx_done, rx bytes arriving while not collecting are dropped.
module alu_uart_ctrl
  import alu_uart_ctrl_pkg::*;
#(
  parameter int NB_DATA     = 8,
  parameter int NB_OP       = 6,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  input  logic               i_tx_done,
  output logic [NB_DATA-1:0] o_alu_a,
  output logic [NB_DATA-1:0] o_alu_b,
  output logic [NB_OP-1:0]   o_alu_op,
  input  logic [NB_DATA-1:0] i_alu_res,
  input  logic               i_alu_carry,
  output logic               o_busy,
  output logic               o_timeout
);

  state_t             state;
  state_t             state_nxt;
  logic [NB_DATA-1:0] result_q;
  logic [NB_DATA-1:0] flags_q;
  logic [NB_DATA-1:0] flags_nxt;
  logic               invalid_q;
  logic               op_ok;
  logic               expire;
  logic               timer_clear;
  logic               timer_en;
  logic               ld_a;
  logic               ld_b;
  logic               ld_op;
  logic               capture;
  logic               timeout_nxt;

  // Upper opcode-byte bits must be zero on top of the low bits being a known opcode.
  assign op_ok = (i_rx_data[NB_DATA-1:NB_OP] == '0) && op_known(i_rx_data[NB_OP-1:0]);

  assign timer_en    = (state == ST_WAIT_B) || (state == ST_WAIT_OP);
  assign timer_clear = i_rx_done || (state == ST_WAIT_A);

  inter_byte_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clear  (timer_clear),
    .i_enable (timer_en),
    .o_expire (expire)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= ST_WAIT_A;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    ld_a        = 1'b0;
    ld_b        = 1'b0;
    ld_op       = 1'b0;
    capture     = 1'b0;
    timeout_nxt = 1'b0;
    case (state)
      ST_WAIT_A: begin
        if (i_rx_done) begin
          ld_a      = 1'b1;
          state_nxt = ST_WAIT_B;
        end
      end
      ST_WAIT_B: begin
        if (i_rx_done) begin
          ld_b      = 1'b1;
          state_nxt = ST_WAIT_OP;
        end else if (expire) begin
          timeout_nxt = 1'b1;
          state_nxt   = ST_WAIT_A;
        end
      end
      ST_WAIT_OP: begin
        if (i_rx_done) begin
          ld_op     = 1'b1;
          state_nxt = ST_EXEC;
        end else if (expire) begin
          timeout_nxt = 1'b1;
          state_nxt   = ST_WAIT_A;
        end
      end
      ST_EXEC: begin
        capture   = 1'b1;
        state_nxt = ST_SEND_RES;
      end
      ST_SEND_RES: state_nxt = ST_WAIT_RES;
      ST_WAIT_RES: if (i_tx_done) state_nxt = ST_SEND_FLG;
      ST_SEND_FLG: state_nxt = ST_WAIT_FLG;
      ST_WAIT_FLG: if (i_tx_done) state_nxt = ST_WAIT_A;
      default:     state_nxt = ST_WAIT_A;
    endcase
  end

  always_comb begin
    o_busy     = (state != ST_WAIT_A);
    o_tx_start = (state == ST_SEND_RES) || (state == ST_SEND_FLG);
    o_tx_data  = result_q;
    if ((state == ST_SEND_FLG) || (state == ST_WAIT_FLG)) begin
      o_tx_data = flags_q;
    end
  end

  always_comb begin
    flags_nxt              = '0;
    flags_nxt[FLG_INVALID] = invalid_q;
    flags_nxt[FLG_CARRY]   = !invalid_q && i_alu_carry;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_alu_a   <= '0;
      o_alu_b   <= '0;
      o_alu_op  <= NB_OP'(OP_ADD);
      invalid_q <= 1'b0;
      result_q  <= '0;
      flags_q   <= '0;
      o_timeout <= 1'b0;
    end else begin
      o_timeout <= timeout_nxt;
      if (ld_a) o_alu_a <= i_rx_data;
      if (ld_b) o_alu_b <= i_rx_data;
      // A rejected opcode leaves the ALU on its previous operation; the result is forced to zero instead.
      if (ld_op) begin
        invalid_q <= !op_ok;
        if (op_ok) o_alu_op <= i_rx_data[NB_OP-1:0];
      end
      if (capture) begin
        result_q <= invalid_q ? '0 : i_alu_res;
        flags_q  <= flags_nxt;
      end
    end
  end

endmodule

// File: tb/tb_alu_uart_ctrl.sv
// Directed bench for alu_uart_ctrl with a behavioural ALU and hand-computed expected bytes.
module tb_alu_uart_ctrl;

  localparam int NB_DATA = 8;
  localparam int NB_OP   = 6;
  localparam int TO_CYC  = 16;

  logic               i_clk = 1'b0;
  logic               i_rst_n;
  logic [NB_DATA-1:0] i_rx_data;
  logic               i_rx_done;
  logic [NB_DATA-1:0] o_tx_data;
  logic               o_tx_start;
  logic               i_tx_done;
  logic [NB_DATA-1:0] o_alu_a;
  logic [NB_DATA-1:0] o_alu_b;
  logic [NB_OP-1:0]   o_alu_op;
  logic [NB_DATA-1:0] i_alu_res;
  logic               i_alu_carry;
  logic               o_busy;
  logic               o_timeout;

  int checks = 0;
  int errs   = 0;

  always #5 i_clk = ~i_clk;

  alu_uart_ctrl #(
    .NB_DATA     (NB_DATA),
    .NB_OP       (NB_OP),
    .TIMEOUT_CYC (TO_CYC)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_rx_data   (i_rx_data),
    .i_rx_done   (i_rx_done),
    .o_tx_data   (o_tx_data),
    .o_tx_start  (o_tx_start),
    .i_tx_done   (i_tx_done),
    .o_alu_a     (o_alu_a),
    .o_alu_b     (o_alu_b),
    .o_alu_op    (o_alu_op),
    .i_alu_res   (i_alu_res),
    .i_alu_carry (i_alu_carry),
    .o_busy      (o_busy),
    .o_timeout   (o_timeout)
  );

  // Behavioural ALU: carry is only produced by ADD.
  logic [8:0] sum;
  always_comb begin
    sum         = {1'b0, o_alu_a} + {1'b0, o_alu_b};
    i_alu_res   = 8'h00;
    i_alu_carry = 1'b0;
    case (o_alu_op)
      6'b100000: begin i_alu_res = sum[7:0]; i_alu_carry = sum[8]; end
      6'b100010: i_alu_res = o_alu_a - o_alu_b;
      6'b100100: i_alu_res = o_alu_a & o_alu_b;
      6'b100101: i_alu_res = o_alu_a | o_alu_b;
      6'b100110: i_alu_res = o_alu_a ^ o_alu_b;
      6'b000011: i_alu_res = $signed(o_alu_a) >>> o_alu_b;
      6'b000010: i_alu_res = o_alu_a >> o_alu_b;
      6'b100111: i_alu_res = ~(o_alu_a | o_alu_b);
      default:   i_alu_res = 8'h00;
    endcase
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_rx_data = b;
    i_rx_done = 1'b1;
    step();
    i_rx_done = 1'b0;
  endtask

  task automatic tx_ack(input int gap);
    repeat (gap) step();
    i_tx_done = 1'b1;
    step();
    i_tx_done = 1'b0;
  endtask

  // Sends the opcode byte (A and B already sent) and checks the two-byte reply.
  task automatic finish_cmd(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] op, input logic [7:0] exp_res,
                            input logic [7:0] exp_flg, input logic [5:0] exp_op,
                            input bit glitch);
    send_byte(op);
    check({tag, "_exec_a"}, o_alu_a, a);
    check({tag, "_exec_b"}, o_alu_b, b);
    check({tag, "_exec_op"}, 8'(o_alu_op), 8'(exp_op));
    check({tag, "_exec_nostart"}, 8'(o_tx_start), 8'd0);
    step();
    check({tag, "_res_start"}, 8'(o_tx_start), 8'd1);
    check({tag, "_res_data"}, o_tx_data, exp_res);
    if (glitch) i_tx_done = 1'b1;
    step();
    i_tx_done = 1'b0;
    check({tag, "_wres_nostart"}, 8'(o_tx_start), 8'd0);
    check({tag, "_wres_hold"}, o_tx_data, exp_res);
    if (glitch) begin
      send_byte(8'h55);
      check({tag, "_drop_a"}, o_alu_a, a);
      check({tag, "_drop_busy"}, 8'(o_busy), 8'd1);
    end
    tx_ack(2);
    check({tag, "_flg_start"}, 8'(o_tx_start), 8'd1);
    check({tag, "_flg_data"}, o_tx_data, exp_flg);
    step();
    check({tag, "_wflg_nostart"}, 8'(o_tx_start), 8'd0);
    tx_ack(1);
    check({tag, "_idle"}, 8'(o_busy), 8'd0);
  endtask

  task automatic run_cmd(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] op, input logic [7:0] exp_res,
                         input logic [7:0] exp_flg, input logic [5:0] exp_op,
                         input bit glitch);
    send_byte(a);
    send_byte(b);
    finish_cmd(tag, a, b, op, exp_res, exp_flg, exp_op, glitch);
  endtask

  initial begin
    bit seen;
    i_rst_n   = 1'b0;
    i_rx_data = 8'h00;
    i_rx_done = 1'b0;
    i_tx_done = 1'b0;
    step();
    step();
    i_rst_n = 1'b1;
    check("rst_a", o_alu_a, 8'h00);
    check("rst_b", o_alu_b, 8'h00);
    check("rst_op", 8'(o_alu_op), 8'h20);
    check("rst_txd", o_tx_data, 8'h00);
    check("rst_start", 8'(o_tx_start), 8'd0);
    check("rst_busy", 8'(o_busy), 8'd0);
    check("rst_to", 8'(o_timeout), 8'd0);

    run_cmd("add",   8'h05, 8'h03, 8'h20, 8'h08, 8'h00, 6'h20, 1'b0);
    run_cmd("addc",  8'hF0, 8'h20, 8'h20, 8'h10, 8'h01, 6'h20, 1'b0);
    run_cmd("sub",   8'h05, 8'h07, 8'h22, 8'hFE, 8'h00, 6'h22, 1'b0);
    run_cmd("inv3f", 8'h11, 8'h22, 8'h3F, 8'h00, 8'h02, 6'h22, 1'b0);
    run_cmd("inve0", 8'h80, 8'h01, 8'hE0, 8'h00, 8'h02, 6'h22, 1'b0);

    // Silence after byte A: pulse lands 16 edges after entering WAIT_B.
    send_byte(8'hAA);
    seen = 1'b0;
    repeat (TO_CYC - 1) begin
      step();
      seen |= o_timeout;
    end
    check("to_early", 8'(seen), 8'd0);
    check("to_busy_pre", 8'(o_busy), 8'd1);
    step();
    check("to_pulse", 8'(o_timeout), 8'd1);
    check("to_idle", 8'(o_busy), 8'd0);
    step();
    check("to_one_cycle", 8'(o_timeout), 8'd0);
    run_cmd("post_to", 8'h0F, 8'h3C, 8'h24, 8'h0C, 8'h00, 6'h24, 1'b0);

    // Byte B arrives in the very cycle the timer would expire.
    send_byte(8'h81);
    repeat (TO_CYC - 1) step();
    send_byte(8'h0F);
    check("race_no_to", 8'(o_timeout), 8'd0);
    check("race_busy", 8'(o_busy), 8'd1);
    finish_cmd("race", 8'h81, 8'h0F, 8'h25, 8'h8F, 8'h00, 6'h25, 1'b0);

    run_cmd("glitch", 8'h5A, 8'hFF, 8'h26, 8'hA5, 8'h00, 6'h26, 1'b1);
    run_cmd("after_glitch", 8'h03, 8'h04, 8'h20, 8'h07, 8'h00, 6'h20, 1'b0);

    // Reset while waiting for the flags byte to finish.
    send_byte(8'h0F);
    send_byte(8'hF0);
    send_byte(8'h27);
    step();
    check("rw_res_start", 8'(o_tx_start), 8'd1);
    step();
    tx_ack(1);
    check("rw_flg_start", 8'(o_tx_start), 8'd1);
    step();
    i_rst_n = 1'b0;
    step();
    i_rst_n = 1'b1;
    check("rw_a", o_alu_a, 8'h00);
    check("rw_b", o_alu_b, 8'h00);
    check("rw_op", 8'(o_alu_op), 8'h20);
    check("rw_txd", o_tx_data, 8'h00);
    check("rw_busy", 8'(o_busy), 8'd0);
    check("rw_to", 8'(o_timeout), 8'd0);
    seen = o_tx_start;
    i_tx_done = 1'b1;
    step();
    i_tx_done = 1'b0;
    repeat (4) begin
      seen |= o_tx_start;
      step();
    end
    check("rw_no_tx", 8'(seen), 8'd0);
    run_cmd("post_rst_srl", 8'h80, 8'h03, 8'h02, 8'h10, 8'h00, 6'h02, 1'b0);
    run_cmd("sra",          8'h80, 8'h02, 8'h03, 8'hE0, 8'h00, 6'h03, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/alu_uart_ctrl.md
Name: alu_uart_ctrl

Overview:
- Sequencer that feeds the shared combinational ALU from a byte stream.
- Collects three bytes from the UART receiver (operand A, operand B, opcode), drives the ALU, captures result and carry, and returns two bytes (result, flags) through the UART transmitter.
- Sits between uart_rx/uart_tx and the ALU instance, which uses SIZE = NB_DATA.

Parameters:
- NB_DATA, 8: byte width; also the ALU operand width.
- NB_OP, 6: ALU opcode width.
- TIMEOUT_CYC, 1000000: maximum idle cycles allowed between bytes of one command before it is aborted.

Ports:
- i_clk  in  1  system clock; single clock domain.
- i_rst_n  in  1  synchronous, active-low reset.
- i_rx_data  in  NB_DATA  received byte; valid only while i_rx_done=1.
- i_rx_done  in  1  one-cycle strobe: byte received.
- o_tx_data  out  NB_DATA  byte to transmit; held stable from the o_tx_start cycle until i_tx_done.
- o_tx_start  out  1  one-cycle pulse: start transmitting o_tx_data.
- i_tx_done  in  1  one-cycle strobe: transmitter finished its byte.
- o_alu_a  out  NB_DATA  operand A to the ALU.
- o_alu_b  out  NB_DATA  operand B to the ALU.
- o_alu_op  out  NB_OP  opcode to the ALU.
- i_alu_res  in  NB_DATA  ALU result.
- i_alu_carry  in  1  ALU carry.
- o_busy  out  1  high in every state except WAIT_A.
- o_timeout  out  1  one-cycle pulse when a partial command is aborted.

Behaviour:
- Reset (i_rst_n=0 sampled at the i_clk edge):
  - state returns to WAIT_A; the timer clears.
  - o_alu_a, o_alu_b, o_tx_data, o_busy, o_timeout and o_tx_start reset to 0.
  - o_alu_op resets to 6'b100000 (ADD).
  - Reset asserted mid-command or mid-transmission discards everything; no further tx pulse follows.
- Valid opcodes: ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, SRA 000011, SRL 000010, NOR 100111.
- An opcode byte is invalid if bits [7:6] are not 0 or bits [5:0] are not in the valid list.
- States:
  - WAIT_A: on i_rx_done, o_alu_a <= i_rx_data; go to WAIT_B.
  - WAIT_B: on i_rx_done, o_alu_b <= i_rx_data; go to WAIT_OP.
  - WAIT_OP: on i_rx_done, if the opcode is valid, o_alu_op <= i_rx_data[5:0] and the internal invalid flag is cleared; if invalid, o_alu_op is unchanged and the invalid flag is set. Go to EXEC.
  - EXEC: one cycle; the ALU output settles. At the closing edge: result_q <= (invalid ? 0 : i_alu_res); flags_q <= {6'b0, invalid, invalid ? 0 : i_alu_carry}. Go to SEND_RES.
  - SEND_RES: o_tx_data = result_q; o_tx_start = 1 for this single cycle; go to WAIT_RES.
  - WAIT_RES: on i_tx_done, go to SEND_FLG.
  - SEND_FLG: o_tx_data = flags_q; o_tx_start = 1 for this single cycle; go to WAIT_FLG.
  - WAIT_FLG: on i_tx_done, go to WAIT_A.
- Latency:
  - o_tx_start for the result byte is high 2 cycles after the cycle in which the opcode's i_rx_done is high.
  - The flags o_tx_start is 1 cycle after the i_tx_done for the result byte.
- Byte and strobe handling:
  - i_rx_done in EXEC, SEND_* or WAIT_RES/WAIT_FLG is ignored; the byte is dropped and no state is changed.
  - i_tx_done outside WAIT_RES/WAIT_FLG is ignored, including the SEND_* cycle itself.
- Timeout:
  - The counter runs only in WAIT_B and WAIT_OP; it clears on every i_rx_done and on entry to WAIT_A.
  - When the count reaches TIMEOUT_CYC-1 with no i_rx_done, the state goes to WAIT_A and o_timeout pulses for one cycle.
  - If i_rx_done and expiry occur in the same cycle, i_rx_done wins and there is no timeout.
  - The counter width is $clog2(TIMEOUT_CYC) and it never wraps.
- The flags byte is always 0x00, 0x01 or 0x02.

Decomposition:
- Shared include alu_defs.vh holds:
  - the 8 opcode localparams (shared with the ALU);
  - the state encodings;
  - the flag bit positions (FLG_CARRY=0, FLG_INVALID=1).
- One sub-module: inter_byte_timer (inputs clear and enable; outputs the expire pulse; parameter TIMEOUT_CYC).
- The FSM and capture registers stay in alu_uart_ctrl.

Test Plan:
- ADD: rx 0x05, 0x03, 0x20 → o_alu_a=0x05, o_alu_b=0x03; tx 0x08 then flags per the ALU carry. o_tx_start exactly 2 cycles after the third i_rx_done.
- SUB: rx 0x05, 0x07, 0x22 → tx 0xFE, then 0x00.
- Invalid opcode: rx 0x11, 0x22, 0x3F (also 0xE0) → tx 0x00, then 0x02; o_alu_op keeps its prior value.
- Timeout with TIMEOUT_CYC=16: rx 0xAA, then silence → o_timeout pulses 16 cycles after entering WAIT_B, state returns to WAIT_A. Then rx 0x0F, 0x3C, 0x24 → tx 0x0C, 0x00.
- Dropped bytes: during WAIT_RES inject i_rx_done with 0x55; i_tx_done during SEND_RES → no state change; sequence completes normally and the next command starts cleanly from byte A.
- Reset during WAIT_FLG (i_rst_n low for 1 cycle) → all outputs at reset values next cycle, no flags tx pulse; a new command then executes correctly.
